// File: rtl/spi_cfg_ctrl_if.sv
// Bundle of SPI pins and configuration outputs for spi_cfg_ctrl.
// The master modport drives the SPI pins; the slave modport is the controller side.
interface spi_cfg_ctrl_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       cfg_update;
    logic [2:0] cfg_addr;
    logic       txn_err;

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle, cfg_update, cfg_addr, txn_err
    );

    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle, cfg_update, cfg_addr, txn_err
    );
endinterface

// File: rtl/spi_cfg_ctrl.sv
// SPI-slave configuration controller: synchronises mode-0 SPI pins into clk, receives
// 16-bit write frames and commits the data byte into one of five configuration registers.
module spi_cfg_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input logic           clk,
    input logic           rst_n,
    spi_cfg_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRecv, StDone, StErr} state_e;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_prev;
    logic                   r_ncs_prev;

    logic                   w_sclk;
    logic                   w_copi;
    logic                   w_ncs;
    logic                   w_sclk_rise;
    logic                   w_ncs_fall;
    logic                   w_ncs_rise;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [15:0]            r_shift;
    logic [4:0]             r_cnt;

    logic                   w_clear;
    logic                   w_shift;
    logic                   w_commit;
    logic                   w_err_set;
    logic                   w_frame_ok;

    logic [7:0]             r_reg0;
    logic [7:0]             r_reg1;
    logic [7:0]             r_reg2;
    logic [7:0]             r_reg3;
    logic [7:0]             r_reg4;
    logic                   r_cfg_update;
    logic [2:0]             r_cfg_addr;
    logic                   r_txn_err;

    // Input synchronisers; ncs idles high so it resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], bus.copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.ncs};
            r_sclk_prev <= w_sclk;
            r_ncs_prev  <= w_ncs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_ncs_fall  = ~w_ncs & r_ncs_prev;
    assign w_ncs_rise  = w_ncs & ~r_ncs_prev;

    assign w_frame_ok  = r_shift[15] && (r_shift[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ncs rise is checked before sclk rise everywhere, so it wins on a shared cycle.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        w_err_set    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_ncs_fall) begin
                    w_clear      = 1'b1;
                    w_state_next = StRecv;
                end
            end
            StRecv: begin
                if (w_ncs_rise) begin
                    w_err_set    = 1'b1;
                    w_state_next = StIdle;
                end else if (w_sclk_rise && !w_ncs) begin
                    w_shift = 1'b1;
                    if (r_cnt == 5'd15) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                if (w_ncs_rise) begin
                    w_state_next = StIdle;
                    if (w_frame_ok) begin
                        w_commit = 1'b1;
                    end else if (r_shift[15]) begin
                        w_err_set = 1'b1;
                    end
                end else if (w_sclk_rise) begin
                    w_state_next = StErr;
                end
            end
            StErr: begin
                if (w_ncs_rise) begin
                    w_err_set    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shift <= {r_shift[14:0], w_copi};
            r_cnt   <= r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg0       <= '0;
            r_reg1       <= '0;
            r_reg2       <= '0;
            r_reg3       <= '0;
            r_reg4       <= '0;
            r_cfg_update <= 1'b0;
            r_cfg_addr   <= '0;
            r_txn_err    <= 1'b0;
        end else begin
            r_cfg_update <= w_commit;
            if (w_commit) begin
                r_cfg_addr <= r_shift[10:8];
                r_txn_err  <= 1'b0;
                case (r_shift[10:8])
                    3'd0:    r_reg0 <= r_shift[7:0];
                    3'd1:    r_reg1 <= r_shift[7:0];
                    3'd2:    r_reg2 <= r_shift[7:0];
                    3'd3:    r_reg3 <= r_shift[7:0];
                    3'd4:    r_reg4 <= r_shift[7:0];
                    default: ;
                endcase
            end else if (w_err_set) begin
                r_txn_err <= 1'b1;
            end
        end
    end

    assign bus.en_reg_out_7_0  = r_reg0;
    assign bus.en_reg_out_15_8 = r_reg1;
    assign bus.en_reg_pwm_7_0  = r_reg2;
    assign bus.en_reg_pwm_15_8 = r_reg3;
    assign bus.pwm_duty_cycle  = r_reg4;
    assign bus.cfg_update      = r_cfg_update;
    assign bus.cfg_addr        = r_cfg_addr;
    assign bus.txn_err         = r_txn_err;

endmodule
